kf8259_interrupt_ack_sequencer: RTL and testbench
=================================================

Name: kf8259_interrupt_ack_sequencer

Overview:
- Sequences the 8086-mode interrupt acknowledge handshake of the KF8259.
- Owns the in-service register, priority rotation and EOI handling, and feeds them back to the priority resolver each cycle.
- Takes the resolver's one-hot `interrupt` result, raises INT to the CPU, runs the two-pulse INTA protocol, and supplies the vector byte.
- Sits between the KF8259 bus/control-word logic and the priority resolver.

Parameters:
- SPURIOUS_LEVEL, 3'd7, IR level reported when no request survives to the first INTA.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- interrupt  input  8  one-hot winning request from the priority resolver (0 = none)
- interrupt_acknowledge_n  input  1  INTA#, already synchronous to clock
- ocw2_write  input  1  single-cycle strobe; ocw2_data valid
- ocw2_data  input  8  {R, SL, EOI, 2'b00, L[2:0]}
- auto_eoi_config  input  1  ICW4 AEOI
- auto_rotate_config  input  1  rotate priority on automatic EOI
- vector_base  input  5  ICW2 T7..T3
- interrupt_to_cpu  output  1  INT pin
- in_service_register  output  8  ISR, to resolver
- highest_level_in_service  output  8  one-hot highest-priority ISR bit under current rotation
- priority_rotate  output  3  lowest-priority level, to resolver
- clear_request  output  8  one-cycle pulse clearing the acknowledged IRR bit
- vector_out  output  8  {vector_base, level}
- vector_out_enable  output  1  high while the vector is driven

Behaviour:
- Clock and reset: single clock domain; all state asynchronously reset by reset_n low.
- Reset values:
  - ISR = 0; priority_rotate = 3'd7 (IR0 highest).
  - interrupt_to_cpu = 0; clear_request = 0; vector_out = 0; vector_out_enable = 0.
  - State = IDLE.
- INTA edge detection: registered copy of interrupt_acknowledge_n. A fall is prev = 1 & cur = 0; a rise is the reverse.
- State machine:
  - IDLE: interrupt_to_cpu = |interrupt (registered, 1-cycle latency). On an INTA fall → ACK1 regardless of INT.
  - ACK1 (entry cycle):
    - Latch ack_level = encoded interrupt, or SPURIOUS_LEVEL if interrupt = 0.
    - ISR[ack_level] <= 1.
    - clear_request = one-hot(ack_level) for exactly 1 cycle.
    - interrupt_to_cpu <= 0.
    - Remain until INTA rise → WAIT2.
  - WAIT2: on INTA fall → ACK2.
  - ACK2: vector_out = {vector_base, ack_level}; vector_out_enable = 1 from the cycle after the fall until the INTA rise. On the rise:
    - if auto_eoi_config: ISR[ack_level] <= 0;
    - if additionally auto_rotate_config: priority_rotate <= ack_level;
    - then → IDLE.
- Between acknowledges, `interrupt` changes are ignored; ack_level is frozen from ACK1.
- highest_level_in_service: combinational. Search ISR starting at level priority_rotate+1 (mod 8) and wrap round to priority_rotate; output the first set bit as one-hot, else 0.
- OCW2 decode (accepted in any state; applied on the strobe cycle):
  - 001 (non-specific EOI): clear the highest_level_in_service bit.
  - 011 (specific EOI): clear ISR[L].
  - 101 (rotate on non-specific EOI): clear the highest bit; priority_rotate <= its level.
  - 111 (rotate on specific EOI): clear ISR[L]; priority_rotate <= L.
  - 110 (set priority): priority_rotate <= L.
  - 100 / 000 (rotate-in-AEOI set/clear): ignored; owned by the control logic.
  - 010: no-op.
- Non-specific EOI with ISR = 0: no change.
- Rotation wraps mod 8 (rotate on level 7 → 3'd7, making IR0 highest).
- Simultaneous events:
  - An ACK1 ISR set and an OCW2 clear of the same bit: the set wins.
  - A clear of a different bit and the set both apply.
  - An OCW2 rotate and an auto-rotate in the same cycle: OCW2 wins.
- INTA rise while in WAIT2/IDLE: ignored.
- Reset mid-acknowledge: returns to IDLE with ISR cleared; vector_out_enable drops asynchronously.

Optional Feature:
- KF8259_SPURIOUS_NO_ISR_EN:
  - Defined: when interrupt = 0 at ACK1, ISR is NOT set and clear_request stays 0. The vector still uses SPURIOUS_LEVEL, and no AEOI clear occurs.
  - Undefined: the spurious level is treated as a normal acknowledge; ISR[SPURIOUS_LEVEL] is set.

Decomposition:
- Shared package KF8259_Common_Package gains:
  - an ack_state_t enum {IDLE, ACK1, WAIT2, ACK2};
  - the OCW2 command constants;
  - encode_level() and highest_from_rotation() functions. These sit next to the existing rotate_right / rotate_left / resolv_priority.
- One sub-module: kf8259_eoi_decoder (OCW2 → clear mask and new rotate value), so it can be verified stand-alone.

Test Plan:
- Reset, then interrupt = 8'h04, vector_base = 5'h08 → INT high 1 cycle later. Two INTA pulses → clear_request = 8'h04 pulse, ISR = 8'h04, vector_out = 8'h42, INT low.
- ISR = 8'h24, rotate = 7, OCW2 = 8'h20 → ISR = 8'h20. Second OCW2 = 8'h20 → ISR = 0. Third → unchanged.
- auto_eoi_config = 1, auto_rotate_config = 1, acknowledge level 3 → ISR stays 0 after the 2nd INTA rise; priority_rotate = 3; highest_level_in_service for ISR = 8'h81 reports 8'h80... = level 7 (search from 4).
- interrupt = 0 at the first INTA → vector_out = {base, 3'd7}. ISR = 8'h80 with the macro undefined; ISR = 0 with KF8259_SPURIOUS_NO_ISR_EN.
- OCW2 = 8'hE5 while ISR = 8'h20 → ISR = 0, priority_rotate = 5. OCW2 = 8'hC1 → priority_rotate = 1.
- reset_n low during ACK2 → vector_out_enable = 0 immediately, state IDLE, ISR = 0; the next INTA pair is acknowledged normally.

Source files
------------

// File: rtl/kf8259_interrupt_ack_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// kf8259_interrupt_ack_sequencer_pkg
// Shared types, constants and helpers for the KF8259 interrupt-acknowledge
// sequencer and its OCW2/EOI decoder.
//   ack_state_t            : acknowledge handshake states
//   OCW2_*                 : OCW2 {R, SL, EOI} command codes
//   level_to_onehot()      : 3-bit level -> one-hot byte
//   encode_level()         : one-hot byte -> 3-bit level (lowest set bit wins)
//   highest_from_rotation(): highest-priority set ISR bit under a rotation
// ---------------------------------------------------------------------------
package kf8259_interrupt_ack_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } ack_state_t;

  // OCW2 command field {R, SL, EOI}
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  function automatic logic [7:0] level_to_onehot(input logic [2:0] level);
    return 8'b0000_0001 << level;
  endfunction

  function automatic logic [2:0] encode_level(input logic [7:0] onehot);
    logic [2:0] level;
    level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (onehot[i]) level = 3'(i);
    end
    return level;
  endfunction

  // Priority order is rotate+1 (highest) ... rotate (lowest). Walking from
  // the lowest priority upwards lets the last hit be the winner.
  function automatic logic [7:0] highest_from_rotation(input logic [7:0] isr,
                                                       input logic [2:0] rotate);
    logic [7:0] result;
    logic [2:0] level;
    result = 8'h00;
    for (int i = 8; i >= 1; i--) begin
      level = rotate + 3'(i);
      if (isr[level]) result = level_to_onehot(level);
    end
    return result;
  endfunction

endpackage

// File: rtl/kf8259_interrupt_ack_sequencer_eoi_decoder.sv
// ---------------------------------------------------------------------------
// kf8259_eoi_decoder
// Decodes an OCW2 strobe into an ISR clear mask and an optional new
// priority_rotate value. Purely combinational.
//   ocw2_write_i               : OCW2 strobe
//   ocw2_command_i             : {R, SL, EOI}
//   ocw2_level_i               : L[2:0]
//   highest_level_in_service_i : one-hot target for non-specific EOIs
//   clear_mask_o               : ISR bits to clear this cycle
//   rotate_en_o / rotate_level_o : load priority_rotate with rotate_level_o
// ---------------------------------------------------------------------------
module kf8259_eoi_decoder
  import kf8259_interrupt_ack_sequencer_pkg::*;
(
  input  logic       ocw2_write_i,
  input  logic [2:0] ocw2_command_i,
  input  logic [2:0] ocw2_level_i,
  input  logic [7:0] highest_level_in_service_i,
  output logic [7:0] clear_mask_o,
  output logic       rotate_en_o,
  output logic [2:0] rotate_level_o
);

  logic       has_highest;
  logic [2:0] highest_level;

  assign has_highest   = |highest_level_in_service_i;
  assign highest_level = encode_level(highest_level_in_service_i);

  always_comb begin
    clear_mask_o   = 8'h00;
    rotate_en_o    = 1'b0;
    rotate_level_o = ocw2_level_i;
    if (ocw2_write_i) begin
      case (ocw2_command_i)
        OCW2_NS_EOI: clear_mask_o = highest_level_in_service_i;
        OCW2_SP_EOI: clear_mask_o = level_to_onehot(ocw2_level_i);
        OCW2_ROT_NS_EOI: begin
          // With nothing in service there is no level to rotate to.
          clear_mask_o   = highest_level_in_service_i;
          rotate_en_o    = has_highest;
          rotate_level_o = highest_level;
        end
        OCW2_ROT_SP_EOI: begin
          clear_mask_o = level_to_onehot(ocw2_level_i);
          rotate_en_o  = 1'b1;
        end
        OCW2_SET_PRI: rotate_en_o = 1'b1;
        // AEOI-rotate set/clear belong to the control-word logic; 010 is a no-op.
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/kf8259_interrupt_ack_sequencer.sv
// ---------------------------------------------------------------------------
// kf8259_interrupt_ack_sequencer
// 8086-mode INTA sequencer: raises INT, runs the two-pulse INTA handshake,
// drives the vector byte, owns the ISR, priority rotation and EOI handling.
// Optional build macro KF8259_SPURIOUS_NO_ISR_EN: a spurious acknowledge
// (no request at the first INTA) neither sets the ISR nor pulses
// clear_request, and skips the automatic EOI.
//   clock_i / reset_n_i          : clock, asynchronous active-low reset
//   interrupt_i                  : one-hot resolver winner (0 = none)
//   interrupt_acknowledge_n_i    : INTA#, synchronous to clock_i
//   ocw2_write_i / ocw2_data_i   : OCW2 strobe and {R,SL,EOI,00,L}
//   auto_eoi_config_i            : AEOI mode
//   auto_rotate_config_i         : rotate on automatic EOI
//   vector_base_i                : T7..T3
//   interrupt_to_cpu_o           : INT pin
//   in_service_register_o        : ISR
//   highest_level_in_service_o   : one-hot highest ISR bit under rotation
//   priority_rotate_o            : lowest-priority level
//   clear_request_o              : one-cycle IRR clear pulse
//   vector_out_o / vector_out_enable_o : vector byte and its enable
// ---------------------------------------------------------------------------
module kf8259_interrupt_ack_sequencer
  import kf8259_interrupt_ack_sequencer_pkg::*;
#(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic [7:0] interrupt_i,
  input  logic       interrupt_acknowledge_n_i,
  input  logic       ocw2_write_i,
  input  logic [7:0] ocw2_data_i,
  input  logic       auto_eoi_config_i,
  input  logic       auto_rotate_config_i,
  input  logic [4:0] vector_base_i,
  output logic       interrupt_to_cpu_o,
  output logic [7:0] in_service_register_o,
  output logic [7:0] highest_level_in_service_o,
  output logic [2:0] priority_rotate_o,
  output logic [7:0] clear_request_o,
  output logic [7:0] vector_out_o,
  output logic       vector_out_enable_o
);

  ack_state_t state_q, state_d;
  logic       inta_prev_q;
  logic [2:0] ack_level_q, ack_level_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] rotate_q, rotate_d;
  logic       int_q, int_d;
  logic [7:0] clear_q, clear_d;

  logic       inta_fall, inta_rise;
  logic [2:0] new_level;
  logic       new_is_real;
  logic       aeoi_allowed;
  logic [7:0] eoi_clear_mask;
  logic       eoi_rotate_en;
  logic [2:0] eoi_rotate_level;
  logic [1:0] unused_ocw2_bits;

  assign inta_fall = inta_prev_q & ~interrupt_acknowledge_n_i;
  assign inta_rise = ~inta_prev_q & interrupt_acknowledge_n_i;
  assign new_level = (interrupt_i == 8'h00) ? SPURIOUS_LEVEL : encode_level(interrupt_i);
  assign unused_ocw2_bits = ocw2_data_i[4:3];

`ifdef KF8259_SPURIOUS_NO_ISR_EN
  logic spurious_q;

  assign new_is_real  = (interrupt_i != 8'h00);
  assign aeoi_allowed = ~spurious_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      spurious_q <= 1'b0;
    end else if (state_q == IDLE && inta_fall) begin
      spurious_q <= (interrupt_i == 8'h00);
    end
  end
`else
  assign new_is_real  = 1'b1;
  assign aeoi_allowed = 1'b1;
`endif

  kf8259_eoi_decoder u_eoi_decoder (
    .ocw2_write_i               (ocw2_write_i),
    .ocw2_command_i             (ocw2_data_i[7:5]),
    .ocw2_level_i               (ocw2_data_i[2:0]),
    .highest_level_in_service_i (highest_level_in_service_o),
    .clear_mask_o               (eoi_clear_mask),
    .rotate_en_o                (eoi_rotate_en),
    .rotate_level_o             (eoi_rotate_level)
  );

  always_comb begin
    state_d     = state_q;
    ack_level_d = ack_level_q;
    isr_d       = isr_q & ~eoi_clear_mask;
    rotate_d    = rotate_q;
    int_d       = 1'b0;
    clear_d     = 8'h00;
    case (state_q)
      IDLE: begin
        if (inta_fall) begin
          state_d     = ACK1;
          ack_level_d = new_level;
          // Applied after the OCW2 clear so a same-bit set wins.
          if (new_is_real) begin
            isr_d   = isr_d | level_to_onehot(new_level);
            clear_d = level_to_onehot(new_level);
          end
        end else begin
          int_d = |interrupt_i;
        end
      end
      ACK1:  if (inta_rise) state_d = WAIT2;
      WAIT2: if (inta_fall) state_d = ACK2;
      ACK2: begin
        if (inta_rise) begin
          state_d = IDLE;
          if (auto_eoi_config_i && aeoi_allowed) begin
            isr_d[ack_level_q] = 1'b0;
            if (auto_rotate_config_i) rotate_d = ack_level_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // An explicit OCW2 rotation overrides an automatic one.
    if (eoi_rotate_en) rotate_d = eoi_rotate_level;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      inta_prev_q <= 1'b1;
      ack_level_q <= 3'd0;
      isr_q       <= 8'h00;
      rotate_q    <= 3'd7;
      int_q       <= 1'b0;
      clear_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      inta_prev_q <= interrupt_acknowledge_n_i;
      ack_level_q <= ack_level_d;
      isr_q       <= isr_d;
      rotate_q    <= rotate_d;
      int_q       <= int_d;
      clear_q     <= clear_d;
    end
  end

  assign interrupt_to_cpu_o         = int_q;
  assign in_service_register_o      = isr_q;
  assign priority_rotate_o          = rotate_q;
  assign clear_request_o            = clear_q;
  assign highest_level_in_service_o = highest_from_rotation(isr_q, rotate_q);
  // Decoded from state so the enable falls with the asynchronous reset.
  assign vector_out_enable_o        = (state_q == ACK2);
  assign vector_out_o               = vector_out_enable_o ? {vector_base_i, ack_level_q} : 8'h00;

endmodule

// File: tb/tb_kf8259_interrupt_ack_sequencer.sv
module tb_kf8259_interrupt_ack_sequencer;

  logic       clock;
  logic       reset_n;
  logic [7:0] interrupt;
  logic       interrupt_acknowledge_n;
  logic       ocw2_write;
  logic [7:0] ocw2_data;
  logic       auto_eoi_config;
  logic       auto_rotate_config;
  logic [4:0] vector_base;
  logic       interrupt_to_cpu;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic [2:0] priority_rotate;
  logic [7:0] clear_request;
  logic [7:0] vector_out;
  logic       vector_out_enable;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: ISR as a byte, rotation as an integer level.
  logic [7:0] m_isr;
  int         m_rot;

`ifdef KF8259_SPURIOUS_NO_ISR_EN
  localparam bit SpuriousNoIsr = 1'b1;
`else
  localparam bit SpuriousNoIsr = 1'b0;
`endif

  kf8259_interrupt_ack_sequencer dut (
    .clock_i                    (clock),
    .reset_n_i                  (reset_n),
    .interrupt_i                (interrupt),
    .interrupt_acknowledge_n_i  (interrupt_acknowledge_n),
    .ocw2_write_i               (ocw2_write),
    .ocw2_data_i                (ocw2_data),
    .auto_eoi_config_i          (auto_eoi_config),
    .auto_rotate_config_i       (auto_rotate_config),
    .vector_base_i              (vector_base),
    .interrupt_to_cpu_o         (interrupt_to_cpu),
    .in_service_register_o      (in_service_register),
    .highest_level_in_service_o (highest_level_in_service),
    .priority_rotate_o          (priority_rotate),
    .clear_request_o            (clear_request),
    .vector_out_o               (vector_out),
    .vector_out_enable_o        (vector_out_enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  // Priority rank: level rot+1 has rank 0, level rot has rank 7.
  function automatic int model_highest_level(input logic [7:0] isr, input int rot);
    int best_rank = 99;
    int best      = -1;
    for (int l = 0; l < 8; l++) begin
      if (isr[l]) begin
        int r;
        r = (((l - rot - 1) % 8) + 8) % 8;
        if (r < best_rank) begin
          best_rank = r;
          best      = l;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [7:0] model_onehot(input int l);
    logic [7:0] v;
    v = 8'h00;
    if (l >= 0) v[l] = 1'b1;
    return v;
  endfunction

  function automatic int model_level(input logic [7:0] irq);
    for (int l = 0; l < 8; l++) if (irq[l]) return l;
    return 7;
  endfunction

  function automatic logic [7:0] model_isr_after_ocw2(input logic [7:0] isr, input int rot,
                                                      input logic [7:0] d);
    int h;
    h = model_highest_level(isr, rot);
    case (d[7:5])
      3'b001, 3'b101: if (h >= 0) isr[h] = 1'b0;
      3'b011, 3'b111: isr[d[2:0]] = 1'b0;
      default: ;
    endcase
    return isr;
  endfunction

  function automatic int model_rot_after_ocw2(input logic [7:0] isr, input int rot,
                                              input logic [7:0] d);
    int h;
    h = model_highest_level(isr, rot);
    case (d[7:5])
      3'b101: if (h >= 0) rot = h;
      3'b111, 3'b110: rot = int'(d[2:0]);
      default: ;
    endcase
    return rot;
  endfunction

  // Stimulus only: one OCW2 strobe, model updated alongside.
  task automatic write_ocw2(input logic [7:0] d);
    logic [7:0] new_isr;
    ocw2_write = 1'b1;
    ocw2_data  = d;
    tick();
    ocw2_write = 1'b0;
    new_isr = model_isr_after_ocw2(m_isr, m_rot, d);
    m_rot   = model_rot_after_ocw2(m_isr, m_rot, d);
    m_isr   = new_isr;
    $display("[TB] ocw2 data=%02h isr=%02h rotate=%0d", d, in_service_register, priority_rotate);
  endtask

  // Stimulus only: remaining INTA edges after ACK1 has been entered.
  task automatic finish_handshake();
    interrupt_acknowledge_n = 1'b1; tick();
    interrupt_acknowledge_n = 1'b0; tick();
    interrupt_acknowledge_n = 1'b1; tick();
  endtask

  // One complete two-pulse acknowledge transaction with its own checks.
  task automatic run_ack(input logic [7:0] irq, input logic aeoi, input logic arot,
                         input logic [4:0] base);
    int         lvl;
    bit         no_isr;
    logic [7:0] exp_clear;
    logic [7:0] exp_vec;
    lvl    = (irq == 8'h00) ? 7 : model_level(irq);
    no_isr = (irq == 8'h00) && SpuriousNoIsr;
    interrupt = irq; auto_eoi_config = aeoi; auto_rotate_config = arot; vector_base = base;
    tick();
    tests_run++;
    if (interrupt_to_cpu !== (irq != 8'h00)) begin
      tests_failed++; $display("FAIL int_raise: got %b expected %b", interrupt_to_cpu, irq != 8'h00);
    end
    interrupt_acknowledge_n = 1'b0;
    tick();
    if (!no_isr) m_isr[lvl] = 1'b1;
    exp_clear = no_isr ? 8'h00 : model_onehot(lvl);
    tests_run++;
    if (clear_request !== exp_clear) begin
      tests_failed++; $display("FAIL clear_pulse: got %02h expected %02h", clear_request, exp_clear);
    end
    tests_run++;
    if (in_service_register !== m_isr) begin
      tests_failed++; $display("FAIL ack1_isr: got %02h expected %02h", in_service_register, m_isr);
    end
    tests_run++;
    if (interrupt_to_cpu !== 1'b0) begin
      tests_failed++; $display("FAIL int_drop: got %b expected 0", interrupt_to_cpu);
    end
    interrupt = 8'($urandom);  // must not disturb the latched level
    tick();
    tests_run++;
    if (clear_request !== 8'h00) begin
      tests_failed++; $display("FAIL clear_one_cycle: got %02h expected 00", clear_request);
    end
    interrupt_acknowledge_n = 1'b1; tick();
    interrupt_acknowledge_n = 1'b0; tick();
    exp_vec = {base, 3'(lvl)};
    tests_run++;
    if (vector_out_enable !== 1'b1 || vector_out !== exp_vec) begin
      tests_failed++;
      $display("FAIL vector: got en=%b vec=%02h expected en=1 vec=%02h", vector_out_enable, vector_out, exp_vec);
    end
    tick();
    interrupt_acknowledge_n = 1'b1;
    tick();
    if (aeoi && !no_isr) begin
      m_isr[lvl] = 1'b0;
      if (arot) m_rot = lvl;
    end
    tests_run++;
    if (vector_out_enable !== 1'b0) begin
      tests_failed++; $display("FAIL vector_release: got en=%b expected 0", vector_out_enable);
    end
    tests_run++;
    if (in_service_register !== m_isr || priority_rotate !== 3'(m_rot)) begin
      tests_failed++;
      $display("FAIL ack_end: got isr=%02h rot=%0d expected isr=%02h rot=%0d",
               in_service_register, priority_rotate, m_isr, m_rot);
    end
    interrupt = 8'h00;
    tick();
    $display("[TB] ack irq=%02h aeoi=%b arot=%b vector=%02h isr=%02h rotate=%0d",
             irq, aeoi, arot, exp_vec, in_service_register, priority_rotate);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    interrupt = 8'h00; interrupt_acknowledge_n = 1'b1; ocw2_write = 1'b0; ocw2_data = 8'h00;
    auto_eoi_config = 1'b0; auto_rotate_config = 1'b0; vector_base = 5'h00;
    m_isr = 8'h00; m_rot = 7;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (in_service_register !== 8'h00 || priority_rotate !== 3'd7 || interrupt_to_cpu !== 1'b0 ||
        clear_request !== 8'h00 || vector_out !== 8'h00 || vector_out_enable !== 1'b0 ||
        highest_level_in_service !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset: got isr=%02h rot=%0d int=%b clr=%02h vec=%02h en=%b hi=%02h expected 00/7/0/00/00/0/00",
               in_service_register, priority_rotate, interrupt_to_cpu, clear_request,
               vector_out, vector_out_enable, highest_level_in_service);
    end
  endtask

  task automatic test_basic_ack();
    run_ack(8'h04, 1'b0, 1'b0, 5'h08);
    tests_run++;
    if (in_service_register !== 8'h04) begin
      tests_failed++; $display("FAIL basic_isr: got %02h expected 04", in_service_register);
    end
  endtask

  task automatic test_ns_eoi();
    logic [7:0] expected [3];
    expected[0] = 8'h20; expected[1] = 8'h00; expected[2] = 8'h00;
    run_ack(8'h20, 1'b0, 1'b0, 5'h08);
    for (int i = 0; i < 3; i++) begin
      write_ocw2(8'h20);
      tests_run++;
      if (in_service_register !== expected[i] || in_service_register !== m_isr) begin
        tests_failed++;
        $display("FAIL ns_eoi_%0d: got %02h expected %02h", i, in_service_register, expected[i]);
      end
    end
  endtask

  task automatic test_aeoi_rotate();
    run_ack(8'h08, 1'b1, 1'b1, 5'h03);
    tests_run++;
    if (in_service_register !== 8'h00 || priority_rotate !== 3'd3) begin
      tests_failed++;
      $display("FAIL aeoi_rotate: got isr=%02h rot=%0d expected isr=00 rot=3", in_service_register, priority_rotate);
    end
    run_ack(8'h01, 1'b0, 1'b0, 5'h03);
    run_ack(8'h80, 1'b0, 1'b0, 5'h03);
    tests_run++;
    if (highest_level_in_service !== 8'h80 || in_service_register !== 8'h81) begin
      tests_failed++;
      $display("FAIL highest_rotated: got hi=%02h isr=%02h expected hi=80 isr=81",
               highest_level_in_service, in_service_register);
    end
    write_ocw2(8'h60);
    write_ocw2(8'h67);
  endtask

  task automatic test_spurious();
    logic [7:0] exp_isr;
    exp_isr = SpuriousNoIsr ? 8'h00 : 8'h80;
    run_ack(8'h00, 1'b0, 1'b0, 5'h11);
    tests_run++;
    if (in_service_register !== exp_isr) begin
      tests_failed++; $display("FAIL spurious_isr: got %02h expected %02h", in_service_register, exp_isr);
    end
    write_ocw2(8'h67);
    run_ack(8'h00, 1'b1, 1'b0, 5'h1f);
  endtask

  task automatic test_specific_rotate();
    run_ack(8'h20, 1'b0, 1'b0, 5'h0a);
    write_ocw2(8'hE5);
    tests_run++;
    if (in_service_register !== 8'h00 || priority_rotate !== 3'd5) begin
      tests_failed++;
      $display("FAIL rot_specific: got isr=%02h rot=%0d expected isr=00 rot=5", in_service_register, priority_rotate);
    end
    write_ocw2(8'hC1);
    tests_run++;
    if (priority_rotate !== 3'd1) begin
      tests_failed++; $display("FAIL set_priority: got %0d expected 1", priority_rotate);
    end
  endtask

  task automatic test_simultaneous();
    run_ack(8'h04, 1'b0, 1'b0, 5'h02);
    run_ack(8'h20, 1'b0, 1'b0, 5'h02);
    // ACK1 set of level 2 together with a specific EOI of level 2: set wins.
    interrupt = 8'h04; tick();
    interrupt_acknowledge_n = 1'b0; ocw2_write = 1'b1; ocw2_data = 8'h62;
    tick();
    ocw2_write = 1'b0; interrupt = 8'h00;
    tests_run++;
    if (in_service_register !== 8'h24) begin
      tests_failed++; $display("FAIL set_wins: got %02h expected 24", in_service_register);
    end
    finish_handshake();
    // ACK1 set of level 2 together with a specific EOI of level 5: both apply.
    interrupt = 8'h04; tick();
    interrupt_acknowledge_n = 1'b0; ocw2_write = 1'b1; ocw2_data = 8'h65;
    tick();
    ocw2_write = 1'b0; interrupt = 8'h00;
    m_isr = 8'h04;
    tests_run++;
    if (in_service_register !== 8'h04) begin
      tests_failed++; $display("FAIL set_and_clear: got %02h expected 04", in_service_register);
    end
    finish_handshake();
    tick();
    $display("[TB] simultaneous set/clear done isr=%02h", in_service_register);
  endtask

  task automatic test_reset_mid_ack();
    interrupt = 8'h10; auto_eoi_config = 1'b0; tick();
    interrupt_acknowledge_n = 1'b0; tick();
    interrupt_acknowledge_n = 1'b1; tick();
    interrupt_acknowledge_n = 1'b0; tick();
    tests_run++;
    if (vector_out_enable !== 1'b1) begin
      tests_failed++; $display("FAIL pre_reset_en: got %b expected 1", vector_out_enable);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (vector_out_enable !== 1'b0 || vector_out !== 8'h00 || in_service_register !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_reset: got en=%b vec=%02h isr=%02h expected 0/00/00",
               vector_out_enable, vector_out, in_service_register);
    end
    tick();
    interrupt = 8'h00; interrupt_acknowledge_n = 1'b1; reset_n = 1'b1;
    m_isr = 8'h00; m_rot = 7;
    tick();
    tests_run++;
    if (priority_rotate !== 3'd7 || in_service_register !== 8'h00) begin
      tests_failed++;
      $display("FAIL post_reset: got rot=%0d isr=%02h expected 7/00", priority_rotate, in_service_register);
    end
    run_ack(8'h02, 1'b0, 1'b0, 5'h15);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        write_ocw2(8'($urandom));
      end else begin
        logic [7:0] irq;
        irq = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
        run_ack(irq, 1'($urandom), 1'($urandom), 5'($urandom));
      end
      tests_run++;
      if (in_service_register !== m_isr || priority_rotate !== 3'(m_rot) ||
          highest_level_in_service !== model_onehot(model_highest_level(m_isr, m_rot))) begin
        tests_failed++;
        $display("FAIL random_%0d: got isr=%02h rot=%0d hi=%02h expected isr=%02h rot=%0d hi=%02h",
                 n, in_service_register, priority_rotate, highest_level_in_service,
                 m_isr, m_rot, model_onehot(model_highest_level(m_isr, m_rot)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_ack();
    test_ns_eoi();
    test_aeoi_rotate();
    test_spurious();
    test_specific_rotate();
    test_simultaneous();
    test_reset_mid_ack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
